// File: rtl/btn_debounce.sv
// btn_debounce
//   Conditions raw push-buttons for the clock core. Each channel runs a
//   2-FF synchroniser (with polarity normalisation to 1 = pressed), a
//   debounce filter that accepts a change only after DEB_CYCLES consecutive
//   agreeing samples, and registered one-cycle press/release/step strobes.
//   While a button stays held, btn_step repeats after REPEAT_DELAY cycles
//   and then every REPEAT_PERIOD cycles (when REPEAT_EN is set).
//
// Ports
//   clk          in   1      system clock, all logic on posedge
//   rst          in   1      synchronous active-high reset
//   btn_raw      in   N_BTN  asynchronous raw button inputs
//   btn_level    out  N_BTN  debounced level, 1 = pressed
//   btn_press    out  N_BTN  one-cycle strobe on accepted press
//   btn_release  out  N_BTN  one-cycle strobe on accepted release
//   btn_step     out  N_BTN  one-cycle strobe on press and on each auto-repeat
module btn_debounce #(
  parameter int N_BTN         = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_step
);

  localparam int CNT_W   = $clog2(DEB_CYCLES) + 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W  = $clog2(RPT_MAX) + 1;

  localparam logic [CNT_W-1:0]  DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PWAIT = 2'd1,
    S_HELD  = 2'd2,
    S_RWAIT = 2'd3
  } state_t;

  // ---- stage p0/p1: synchroniser, already normalised to 1 = pressed ----
  logic [N_BTN-1:0] r_sync_p0;
  logic [N_BTN-1:0] r_sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // ---- stage p2: per-channel debounce / repeat FSM with registered strobes ----
  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [RCNT_W-1:0]   r_rcnt;
    logic [RCNT_W-1:0]   w_rcnt_nxt;
    logic [RCNT_W-1:0]   w_rlimit;
    logic [RCNT_W-1:0]   w_rcnt_inc;
    logic                r_first;
    logic                w_first_nxt;
    logic                r_level;
    logic                w_level_nxt;
    logic                r_press;
    logic                w_press_nxt;
    logic                r_release;
    logic                w_release_nxt;
    logic                r_step;
    logic                w_step_nxt;
    logic                w_sync;

    assign w_sync   = r_sync_p1[g];
    // r_first marks that the initial repeat delay has already elapsed
    assign w_rlimit = r_first ? PERIOD_LAST : DELAY_LAST;
    // Repeat counter keeps running while held (including RWAIT) but parks at
    // its compare value so it never wraps.
    assign w_rcnt_inc = (r_rcnt != w_rlimit) ? (r_rcnt + RCNT_W'(1)) : r_rcnt;

    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_rcnt_nxt    = r_rcnt;
      w_first_nxt   = r_first;
      w_level_nxt   = r_level;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      w_step_nxt    = 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_sync) begin
            w_state_nxt = S_PWAIT;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        S_PWAIT: begin
          if (!w_sync) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DEB_LAST) begin
            w_state_nxt = S_HELD;
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b1;
            w_press_nxt = 1'b1;
            w_step_nxt  = 1'b1;
            w_rcnt_nxt  = '0;
            w_first_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_HELD: begin
          if (!w_sync) begin
            w_state_nxt = S_RWAIT;
            w_cnt_nxt   = CNT_W'(1);
            w_rcnt_nxt  = w_rcnt_inc;
          end else if ((REPEAT_EN != 0) && (r_rcnt == w_rlimit)) begin
            w_step_nxt  = 1'b1;
            w_rcnt_nxt  = '0;
            w_first_nxt = 1'b1;
          end else begin
            w_rcnt_nxt = w_rcnt_inc;
          end
        end
        S_RWAIT: begin
          // No repeat step can fire here; returning to HELD is silent.
          w_rcnt_nxt = w_rcnt_inc;
          if (w_sync) begin
            w_state_nxt = S_HELD;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DEB_LAST) begin
            w_state_nxt   = S_IDLE;
            w_cnt_nxt     = '0;
            w_level_nxt   = 1'b0;
            w_release_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_rcnt    <= '0;
        r_first   <= 1'b0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_step    <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_rcnt    <= w_rcnt_nxt;
        r_first   <= w_first_nxt;
        r_level   <= w_level_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
        r_step    <= w_step_nxt;
      end
    end

    assign btn_level[g]   = r_level;
    assign btn_press[g]   = r_press;
    assign btn_release[g] = r_release;
    assign btn_step[g]    = r_step;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios followed by random button
// activity, compared every cycle against a run-length reference model.
module tb_btn_debounce;
  localparam int NB  = 4;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = 4'hF;
  logic [NB-1:0] lvl, prs, rel, stp;
  logic [NB-1:0] lvl_n, prs_n, rel_n, stp_n;

  btn_debounce #(
    .N_BTN(NB), .ACTIVE_LOW(1), .DEB_CYCLES(DEB),
    .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(lvl), .btn_press(prs), .btn_release(rel), .btn_step(stp)
  );

  btn_debounce #(
    .N_BTN(NB), .ACTIVE_LOW(1), .DEB_CYCLES(DEB),
    .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_nr (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(lvl_n), .btn_press(prs_n), .btn_release(rel_n), .btn_step(stp_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_press[NB];
  int n_rel[NB];
  int n_step[NB];

  // Reference model: synchroniser history, stable level, length of the
  // current run of samples disagreeing with the level, and held-cycle count
  // since the last step.
  bit   m_s1[NB];
  bit   m_s2[NB];
  bit   m_lvl[NB];
  bit   m_first[NB];
  int   m_run[NB];
  int   m_hc[NB];
  logic [NB-1:0] e_lvl = '0, e_press = '0, e_rel = '0, e_step = '0;

  task automatic model_update();
    bit s;
    int lim;
    e_press = '0;
    e_rel   = '0;
    e_step  = '0;
    for (int c = 0; c < NB; c++) begin
      if (rst) begin
        m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_first[c] = 0;
        m_run[c] = 0; m_hc[c] = 0;
      end else begin
        s   = m_s2[c];
        lim = m_first[c] ? RP : RD;
        if (m_lvl[c]) begin
          if (s && m_run[c] == 0) begin
            if (m_hc[c] == lim - 1) begin
              e_step[c] = 1'b1; m_hc[c] = 0; m_first[c] = 1;
            end else begin
              m_hc[c]++;
            end
          end else if (m_hc[c] < lim - 1) begin
            m_hc[c]++;
          end
        end
        if (s != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB) begin
            m_lvl[c] = s;
            m_run[c] = 0;
            if (s) begin
              e_press[c] = 1'b1; e_step[c] = 1'b1; m_hc[c] = 0; m_first[c] = 0;
            end else begin
              e_rel[c] = 1'b1;
            end
          end
        end else begin
          m_run[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = ~btn_raw[c];
      end
      e_lvl[c] = m_lvl[c];
    end
  endtask

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
    chk("level", lvl, e_lvl);
    chk("press", prs, e_press);
    chk("release", rel, e_rel);
    chk("step", stp, e_step);
    chk("nr_level", lvl_n, e_lvl);
    chk("nr_press", prs_n, e_press);
    chk("nr_release", rel_n, e_rel);
    chk("nr_step", stp_n, e_press);
    for (int c = 0; c < NB; c++) begin
      n_press[c] += int'(prs[c]);
      n_rel[c]   += int'(rel[c]);
      n_step[c]  += int'(stp[c]);
    end
  endtask

  initial begin
    int bp, bs, br;
    for (int c = 0; c < NB; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_step[c] = 0;
      m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_first[c] = 0;
      m_run[c] = 0; m_hc[c] = 0;
    end

    // Reset state
    rst = 1'b1; btn_raw = 4'hF;
    repeat (3) tick();
    chk("rst_level", lvl, 4'h0);
    chk("rst_press", prs, 4'h0);
    chk("rst_release", rel, 4'h0);
    chk("rst_step", stp, 4'h0);
    rst = 1'b0;
    repeat (6) tick();

    // Clean press on button 0
    bp = n_press[0];
    btn_raw[0] = 1'b0;
    repeat (5) tick();
    chk("press0_early", 4'(n_press[0] - bp), 4'd0);
    tick();
    chk("press0_at", prs, 4'b0001);
    chk("step0_at", stp, 4'b0001);
    tick();
    chk("level0_after", lvl, 4'b0001);
    chk("press0_once", prs, 4'b0000);
    repeat (3) tick();
    btn_raw[0] = 1'b1;
    repeat (10) tick();

    // Bounce on button 1: low 3, high 1, then steady low
    bp = n_press[1];
    btn_raw[1] = 1'b0; repeat (3) tick();
    btn_raw[1] = 1'b1; tick();
    btn_raw[1] = 1'b0; repeat (5) tick();
    chk("bounce_none", 4'(n_press[1] - bp), 4'd0);
    tick();
    chk("bounce_press", prs, 4'b0010);
    btn_raw[1] = 1'b1;
    repeat (10) tick();

    // Auto-repeat on button 2: steps at P, P+10, P+13, P+16
    bp = n_press[2]; bs = n_step[2];
    btn_raw[2] = 1'b0;
    repeat (22) tick();
    chk("rpt_steps", 4'(n_step[2] - bs), 4'd4);
    chk("rpt_press", 4'(n_press[2] - bp), 4'd1);

    // Release with a 2-cycle re-press glitch inside the release window
    br = n_rel[2];
    btn_raw[2] = 1'b1; repeat (3) tick();
    btn_raw[2] = 1'b0; repeat (2) tick();
    btn_raw[2] = 1'b1; repeat (5) tick();
    chk("glitch_norel", 4'(n_rel[2] - br), 4'd0);
    repeat (7) tick();
    chk("glitch_onerel", 4'(n_rel[2] - br), 4'd1);

    // Simultaneous press on all channels
    btn_raw = 4'h0;
    repeat (5) tick();
    tick();
    chk("simul_press", prs, 4'hF);
    btn_raw = 4'hF;
    repeat (12) tick();

    // Reset while button 0 is mid-debounce
    btn_raw[0] = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("midrst_level", lvl, 4'h0);
    chk("midrst_press", prs, 4'h0);
    chk("midrst_step", stp, 4'h0);
    chk("midrst_nr_level", lvl_n, 4'h0);
    rst = 1'b0;
    bp = n_press[0];
    repeat (5) tick();
    chk("midrst_none", 4'(n_press[0] - bp), 4'd0);
    tick();
    chk("midrst_repress", prs, 4'b0001);
    btn_raw = 4'hF;
    repeat (10) tick();

    // Random activity with occasional resets
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NB; c++) begin
        if ($urandom_range(0, 15) == 0) btn_raw[c] = ~btn_raw[c];
      end
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;
    btn_raw = 4'hF;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
